// File: rtl/race_pkg.sv
// Shared state encodings, widths and conversion constants for the race dynamics slice.
// target_speed() maps rpm and gear to a gear-limited road speed.
package race_pkg;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] COUNTDOWN = 2'd1;
    localparam logic [1:0] RACING    = 2'd2;
    localparam logic [1:0] FINISHED  = 2'd3;

    localparam int unsigned TICKS_PER_S   = 100;
    localparam int unsigned UNITS_PER_M   = 360;
    localparam int unsigned RATIO_G1_DEF  = 12;
    localparam int unsigned RATIO_G2_DEF  = 20;
    localparam int unsigned RATIO_G3_DEF  = 28;
    localparam int unsigned MAX_SPEED_DEF = 359;
    localparam int unsigned MAX_RPM       = 11000;

    localparam int unsigned RPM_W   = 14;
    localparam int unsigned GEAR_W  = 2;
    localparam int unsigned SPEED_W = 9;
    localparam int unsigned DIST_W  = 10;
    localparam int unsigned TIME_W  = 16;
    localparam int unsigned PROD_W  = 20;
    localparam int unsigned FRAC_W  = 9;

    // Speed the car settles at for a given rpm and gear; neutral yields 0.
    function automatic logic [SPEED_W-1:0] target_speed(
        input logic [RPM_W-1:0]  rpm,
        input logic [GEAR_W-1:0] gear,
        input int unsigned       r1,
        input int unsigned       r2,
        input int unsigned       r3,
        input int unsigned       max_speed
    );
        logic [RPM_W-1:0]  rpm_c;
        logic [PROD_W-1:0] ratio;
        logic [PROD_W-1:0] prod;
        logic [PROD_W-1:0] scaled;
        rpm_c = (32'(rpm) > MAX_RPM) ? RPM_W'(MAX_RPM) : rpm;
        case (gear)
            2'd1:    ratio = PROD_W'(r1);
            2'd2:    ratio = PROD_W'(r2);
            default: ratio = PROD_W'(r3);
        endcase
        prod   = PROD_W'(rpm_c) * ratio;
        scaled = prod >> 10;
        if (gear == 2'd0) begin
            return '0;
        end
        if (32'(scaled) > max_speed) begin
            return SPEED_W'(max_speed);
        end
        return SPEED_W'(scaled);
    endfunction

endpackage

// File: rtl/distance_accum.sv
// Integrates speed into whole metres through a modulo-360 fractional accumulator.
// distance_next_c exposes the value distance_m will take on the coming edge.
module distance_accum
    import race_pkg::*;
(
    input  logic               clk100Hz,
    input  logic               rst,
    input  logic [SPEED_W-1:0] speed,
    input  logic               enable,
    input  logic               clear,
    output logic [DIST_W-1:0]  distance_m,
    output logic [DIST_W-1:0]  distance_next_c
);

    localparam int unsigned SUM_W = FRAC_W + 1;

    logic [FRAC_W-1:0] frac_q;
    logic [FRAC_W-1:0] frac_d;
    logic [SUM_W-1:0]  sum;

    assign sum = SUM_W'(frac_q) + SUM_W'(speed);

    // Speed is capped below 360, so at most one metre carries out per tick.
    always_comb begin
        frac_d          = frac_q;
        distance_next_c = distance_m;
        if (clear) begin
            frac_d          = '0;
            distance_next_c = '0;
        end else if (enable) begin
            if (sum >= SUM_W'(UNITS_PER_M)) begin
                frac_d          = FRAC_W'(sum - SUM_W'(UNITS_PER_M));
                distance_next_c = distance_m + DIST_W'(1);
            end else begin
                frac_d = FRAC_W'(sum);
            end
        end
    end

    always_ff @(posedge clk100Hz) begin
        if (rst) begin
            frac_q     <= '0;
            distance_m <= '0;
        end else begin
            frac_q     <= frac_d;
            distance_m <= distance_next_c;
        end
    end

endmodule

// File: rtl/race_dynamics.sv
// Race sequencer: staging, 3-step countdown, racing with speed tracking and timing,
// finish and false-start detection. One update per 10 ms tick.
module race_dynamics
    import race_pkg::*;
#(
    parameter int unsigned RACE_LEN_M  = 402,
    parameter int unsigned COUNT_TICKS = TICKS_PER_S,
    parameter int unsigned RATIO_G1    = RATIO_G1_DEF,
    parameter int unsigned RATIO_G2    = RATIO_G2_DEF,
    parameter int unsigned RATIO_G3    = RATIO_G3_DEF,
    parameter int unsigned MAX_SPEED   = MAX_SPEED_DEF
) (
    input  logic               clk100Hz,
    input  logic               rst,
    input  logic               reset_status,
    input  logic               start_race,
    input  logic [RPM_W-1:0]   rpm,
    input  logic [GEAR_W-1:0]  gear,
    output logic [SPEED_W-1:0] speed,
    output logic [DIST_W-1:0]  distance_m,
    output logic [TIME_W-1:0]  race_time_cs,
    output logic [1:0]         countdown,
    output logic               finished,
    output logic               false_start,
    output logic [1:0]         state
);

    localparam int unsigned TICK_W = (COUNT_TICKS > 1) ? $clog2(COUNT_TICKS) : 1;

    logic               sync_rst;
    logic [TICK_W-1:0]  tick_q;
    logic [TICK_W-1:0]  tick_d;
    logic [1:0]         state_d;
    logic [1:0]         countdown_d;
    logic [SPEED_W-1:0] speed_d;
    logic [TIME_W-1:0]  time_d;
    logic               false_start_d;
    logic [SPEED_W-1:0] target_c;
    logic               acc_en;
    logic               acc_clr;
    logic [DIST_W-1:0]  dist_next_c;

    assign sync_rst = rst | reset_status;
    assign target_c = target_speed(rpm, gear, RATIO_G1, RATIO_G2, RATIO_G3, MAX_SPEED);

    distance_accum u_distance_accum (
        .clk100Hz        (clk100Hz),
        .rst             (sync_rst),
        .speed           (speed_d),
        .enable          (acc_en),
        .clear           (acc_clr),
        .distance_m      (distance_m),
        .distance_next_c (dist_next_c)
    );

    always_ff @(posedge clk100Hz) begin
        if (sync_rst) begin
            state        <= IDLE;
            tick_q       <= '0;
            countdown    <= '0;
            speed        <= '0;
            race_time_cs <= '0;
            false_start  <= 1'b0;
            finished     <= 1'b0;
        end else begin
            state        <= state_d;
            tick_q       <= tick_d;
            countdown    <= countdown_d;
            speed        <= speed_d;
            race_time_cs <= time_d;
            false_start  <= false_start_d;
            finished     <= (state_d == FINISHED);
        end
    end

    always_comb begin
        state_d       = state;
        tick_d        = tick_q;
        countdown_d   = countdown;
        speed_d       = speed;
        time_d        = race_time_cs;
        false_start_d = false_start;
        acc_en        = 1'b0;
        acc_clr       = 1'b0;
        case (state)
            IDLE: begin
                speed_d     = '0;
                time_d      = '0;
                countdown_d = '0;
                acc_clr     = 1'b1;
                if (start_race) begin
                    state_d     = COUNTDOWN;
                    countdown_d = 2'd3;
                    tick_d      = '0;
                end
            end
            COUNTDOWN: begin
                speed_d = '0;
                // Moving off early beats the light change on the same tick.
                if (gear != 2'd0) begin
                    false_start_d = 1'b1;
                    state_d       = FINISHED;
                    countdown_d   = '0;
                    time_d        = '0;
                end else if (tick_q == TICK_W'(COUNT_TICKS - 1)) begin
                    tick_d = '0;
                    if (countdown == 2'd1) begin
                        state_d     = RACING;
                        countdown_d = '0;
                    end else begin
                        countdown_d = countdown - 2'd1;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            RACING: begin
                if (speed < target_c) begin
                    speed_d = speed + SPEED_W'(1);
                end else if (speed > target_c) begin
                    speed_d = speed - SPEED_W'(1);
                end
                if (race_time_cs != '1) begin
                    time_d = race_time_cs + TIME_W'(1);
                end
                acc_en = 1'b1;
                if (32'(dist_next_c) >= RACE_LEN_M) begin
                    state_d = FINISHED;
                end
            end
            default: begin
                if (speed != '0) begin
                    speed_d = speed - SPEED_W'(1);
                end
            end
        endcase
    end

endmodule

// File: doc/race_dynamics.md
Name: race_dynamics

Overview:
- Consumes engine rpm and selected gear from the rpm stage and converts them into vehicle speed, travelled distance and race time.
- Runs the race sequence: staging, 3 s countdown, racing, finish, with false-start detection.
- Feeds the HUD/cockpit and result display logic.
- One update per clk100Hz tick (100 Hz, 10 ms).

Parameters:
- RACE_LEN_M, 402: race length in metres; finish when distance_m >= RACE_LEN_M.
- COUNT_TICKS, 100: ticks per countdown step (1 s).
- RATIO_G1, 12: gear-1 speed ratio; target = (rpm*ratio)>>10.
- RATIO_G2, 20: gear-2 ratio.
- RATIO_G3, 28: gear-3 ratio.
- MAX_SPEED, 359: speed ceiling in km/h; must be <=359.

Ports:
- clk100Hz  in  1  system tick clock.
- rst  in  1  reset, synchronous, active-high.
- reset_status  in  1  game restart; synchronous, same effect as rst.
- start_race  in  1  one-tick pulse; starts countdown from IDLE.
- rpm  in  14  engine rpm from the rpm stage, 0..11000.
- gear  in  2  current gear from the rpm stage; 0 = neutral.
- speed  out  9  vehicle speed, km/h.
- distance_m  out  10  metres travelled in this race.
- race_time_cs  out  16  race time in centiseconds.
- countdown  out  2  lights value: 3,2,1 during countdown, else 0.
- finished  out  1  high in FINISHED.
- false_start  out  1  sticky until reset; set on gear!=0 during countdown.
- state  out  2  IDLE=0, COUNTDOWN=1, RACING=2, FINISHED=3.

Behaviour:
- Reset (rst or reset_status, sampled on clock edge): state=IDLE and all outputs 0, including internal frac accumulator and countdown tick counter. Takes effect from any state, mid-race included.
- All outputs are registered and update one tick after the inputs that cause them.
- Target speed, combinational:
  - gear 0 gives 0.
  - Otherwise min((rpm*RATIO_Gn)>>10, MAX_SPEED), using a 20-bit product.
  - Example: rpm 11000, gear 1 gives 128; gear 3 gives 300.
- IDLE:
  - speed, distance_m, race_time_cs and countdown are held at 0.
  - start_race moves to COUNTDOWN, with countdown=3 and tick counter=0.
- COUNTDOWN:
  - Tick counter counts 0..COUNT_TICKS-1. On wrap, countdown decrements.
  - When the wrap occurs with countdown==1, move to RACING and set countdown to 0.
  - Total duration is exactly 3*COUNT_TICKS ticks.
  - speed is held at 0 and start_race is ignored.
  - If gear!=0 on any COUNTDOWN tick: false_start=1, go to FINISHED, countdown=0, race_time_cs=0. A gear change takes priority over the countdown wrap on the same tick.
- RACING:
  - Speed steps one per tick toward the target: +1 if below, -1 if above, unchanged if equal. The result never exceeds MAX_SPEED.
  - race_time_cs increments each tick and saturates at 65535.
  - Distance: frac = frac + speed_new. If the sum is >=360, subtract 360 and increment distance_m (1 km/h for 10 ms = 1/360 m).
  - MAX_SPEED <= 359 guarantees at most one carry per tick. frac stays in 0..359.
  - When distance_m reaches >= RACE_LEN_M, move to FINISHED on that same edge. race_time_cs includes the finishing tick.
  - start_race is ignored.
- FINISHED:
  - finished=1. race_time_cs and distance_m are frozen.
  - speed decrements by 1 per tick to 0, regardless of rpm and gear.
  - Stays in FINISHED until rst or reset_status.
- Simultaneous events: reset has priority over everything. start_race in any state other than IDLE is ignored.
- distance_m never exceeds RACE_LEN_M (the FSM stops accumulating there). 10 bits covers this, since RACE_LEN_M <= 1023.

Decomposition:
- Shared package, race_pkg:
  - State encodings IDLE, COUNTDOWN, RACING, FINISHED.
  - Constants TICKS_PER_S=100, UNITS_PER_M=360, default gear ratios, MAX_RPM=11000.
- Sub-module distance_accum:
  - Inputs: speed, enable, clear.
  - Outputs: distance_m; frac is kept internal.
  - Contains the modulo-360 accumulator and the metre counter.
- The FSM, countdown, timer and speed tracker stay in race_dynamics.

Test Plan:
- Countdown: reset, then a start_race pulse with gear=0 -> countdown reads 3,2,1 for 100 ticks each, state=RACING at tick 300, countdown=0.
- Speed ramp: RACING, gear=1, rpm=11000 held -> speed increases 1/tick and reaches 128 after 128 ticks, then holds 128. Switching to gear=3 -> speed climbs to 300.
- Distance: force speed to a constant 36 -> distance_m increments every 10 ticks. Speed 0 gives no change.
- Finish: drive to 402 m -> finished=1 on the tick distance_m becomes 402; race_time_cs frozen; speed decays 1/tick to 0; rpm/gear changes have no effect.
- False start: gear=1 at countdown tick 150 -> next tick state=FINISHED, false_start=1, race_time_cs=0, distance_m=0.
- Reset mid-race: reset_status pulse at race_time_cs=500 -> next tick state=IDLE with all outputs 0. A subsequent start_race restarts the countdown from 3.
